// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle for imem_fetch_ctrl: loader port, instruction memory port,
// CPU fetch/control port and status outputs. master = the controller.
interface imem_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    // loader
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;
    // instruction memory
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] pc_out;
    logic [DATA_W-1:0] iw_in;
    // CPU control
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              cpu_en;
    logic              halted;
    // status
    logic              load_err;
    logic              fetch_err;
    logic [ADDR_W-1:0] ld_count;
    logic [31:0]       instr_count;

    modport master (
        input  ld_valid, ld_addr, ld_data, ld_done, iw_in,
               stall, redirect, redirect_pc,
        output ld_ready, mem_we, mem_waddr, mem_wdata, pc_out,
               cpu_en, halted, load_err, fetch_err, ld_count, instr_count
    );

    modport slave (
        output ld_valid, ld_addr, ld_data, ld_done, iw_in,
               stall, redirect, redirect_pc,
        input  ld_ready, mem_we, mem_waddr, mem_wdata, pc_out,
               cpu_en, halted, load_err, fetch_err, ld_count, instr_count
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory fetch controller: LOAD phase writes loader words into
// instruction memory, RUN phase generates the fetch PC and gates CPU commits,
// HALT freezes everything until reset.
module imem_fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 66,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'b111111
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ld_count_q, ld_count_d;
    logic [31:0]       instr_count_q, instr_count_d;
    logic              load_err_q, load_err_d;
    logic              fetch_err_q, fetch_err_d;
    logic              halted_q, halted_d;

    logic              ld_ready;
    logic              mem_we;
    logic              cpu_en;
    logic              is_halt;
    logic              ld_in_range;
    logic [ADDR_W-1:0] next_pc;

    // Next-state, counters, error flags and same-cycle handshake outputs.
    // Reset is folded in here so combinational outputs show LOAD behaviour
    // while rst is high, whatever the current state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ld_count_d    = ld_count_q;
        instr_count_d = instr_count_q;
        load_err_d    = load_err_q;
        fetch_err_d   = fetch_err_q;
        halted_d      = halted_q;
        ld_ready      = 1'b0;
        mem_we        = 1'b0;
        cpu_en        = 1'b0;
        next_pc       = '0;
        is_halt       = (bus.iw_in[DATA_W-1 -: 6] == HALT_OP);
        ld_in_range   = ({1'b0, bus.ld_addr} < LIMIT);

        if (rst) begin
            state_d       = ST_LOAD;
            pc_d          = RESET_PC;
            ld_count_d    = '0;
            instr_count_d = '0;
            load_err_d    = 1'b0;
            fetch_err_d   = 1'b0;
            halted_d      = 1'b0;
            ld_ready      = 1'b1;
            mem_we        = bus.ld_valid & ld_in_range;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    ld_ready = 1'b1;
                    if (bus.ld_valid) begin
                        if (ld_in_range) begin
                            mem_we     = 1'b1;
                            ld_count_d = ld_count_q + 1'b1;
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end
                    if (bus.ld_done) begin
                        state_d = ST_RUN;
                        pc_d    = RESET_PC;
                    end
                end
                ST_RUN: begin
                    cpu_en = ~bus.stall & ~is_halt;
                    if (bus.stall) begin
                        // hold; a pending redirect is re-presented after the stall
                    end else if (is_halt) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        next_pc = bus.redirect ? bus.redirect_pc : pc_q + 1'b1;
                        pc_d    = next_pc;
                        if (instr_count_q != '1) begin
                            instr_count_d = instr_count_q + 32'd1;
                        end
                        if ({1'b0, next_pc} >= LIMIT) begin
                            fetch_err_d = 1'b1;
                            state_d     = ST_HALT;
                            halted_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    // ST_HALT: everything holds until reset
                end
            endcase
        end
    end

    // Register all controller state.
    always_ff @(posedge clk) begin
        state_q       <= state_d;
        pc_q          <= pc_d;
        ld_count_q    <= ld_count_d;
        instr_count_q <= instr_count_d;
        load_err_q    <= load_err_d;
        fetch_err_q   <= fetch_err_d;
        halted_q      <= halted_d;
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.mem_we      = mem_we;
    assign bus.mem_waddr   = bus.ld_addr;
    assign bus.mem_wdata   = bus.ld_data;
    assign bus.pc_out      = pc_q;
    assign bus.cpu_en      = cpu_en;
    assign bus.halted      = halted_q;
    assign bus.load_err    = load_err_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.ld_count    = ld_count_q;
    assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: the driver computes expected outputs
// from a behavioural model and queues them; a monitor compares at negedge.
module tb_imem_fetch_ctrl;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 66;
    localparam logic [5:0]  HALT_OP = 6'b111111;

    logic clk = 1'b0;
    logic rst;

    imem_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_fetch_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RESET_PC(16'd0),
        .HALT_OP (HALT_OP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Environment instruction memory, written only through the DUT's port.
    bit [31:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_waddr < DEPTH) env_mem[bus.mem_waddr] <= bus.mem_wdata;
    end
    assign bus.iw_in = (bus.pc_out < DEPTH) ? env_mem[bus.pc_out] : 32'h0;

    typedef struct {
        logic        ld_ready;
        logic        mem_we;
        logic        cpu_en;
        logic [15:0] pc;
        logic        halted;
        logic        load_err;
        logic        fetch_err;
        logic [15:0] ld_count;
        logic [31:0] instr_count;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase flags, PC, counters and a memory image.
    bit [31:0]   ref_mem [DEPTH];
    bit          ref_run = 1'b0;
    bit          ref_stop = 1'b0;
    int unsigned ref_pc = 0;
    int unsigned ref_ld_count = 0;
    int unsigned ref_instr = 0;
    bit          ref_load_err = 1'b0;
    bit          ref_fetch_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected outputs for the current cycle, then the model advances one edge.
    task automatic ref_cycle();
        exp_t        e;
        wr_t         w;
        bit          in_rng;
        bit          hlt;
        int unsigned nxt;
        in_rng = (bus.ld_addr < DEPTH);
        hlt = ref_run && (ref_pc < DEPTH) && (ref_mem[ref_pc][31:26] == HALT_OP);
        e.ld_ready    = rst || (!ref_run && !ref_stop);
        e.mem_we      = e.ld_ready && bus.ld_valid && in_rng;
        e.cpu_en      = !rst && ref_run && !bus.stall && !hlt;
        e.pc          = 16'(ref_pc);
        e.halted      = ref_stop;
        e.load_err    = ref_load_err;
        e.fetch_err   = ref_fetch_err;
        e.ld_count    = 16'(ref_ld_count);
        e.instr_count = ref_instr;
        exp_q.push_back(e);
        if (e.mem_we) begin
            w.addr = bus.ld_addr;
            w.data = bus.ld_data;
            wr_q.push_back(w);
        end
        if (rst) begin
            ref_run = 0; ref_stop = 0; ref_pc = 0; ref_ld_count = 0;
            ref_instr = 0; ref_load_err = 0; ref_fetch_err = 0;
        end else if (!ref_run && !ref_stop) begin
            if (bus.ld_valid) begin
                if (in_rng) begin
                    ref_mem[bus.ld_addr] = bus.ld_data;
                    ref_ld_count = (ref_ld_count + 1) % 65536;
                end else begin
                    ref_load_err = 1;
                end
            end
            if (bus.ld_done) begin
                ref_run = 1;
                ref_pc  = 0;
            end
        end else if (ref_run && !bus.stall) begin
            if (hlt) begin
                ref_run = 0; ref_stop = 1;
            end else begin
                nxt = bus.redirect ? int'(bus.redirect_pc) : (ref_pc + 1) % 65536;
                if (ref_instr != 32'hFFFF_FFFF) ref_instr++;
                ref_pc = nxt;
                if (nxt >= DEPTH) begin
                    ref_fetch_err = 1; ref_run = 0; ref_stop = 1;
                end
            end
        end
    endtask

    task automatic step();
        ref_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_done = 0;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    endtask

    function automatic logic [31:0] rand_word(input bit allow_halt);
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == HALT_OP) w[31] = 1'b0;
        if (allow_halt && $urandom_range(0, 11) == 0) w[31:26] = HALT_OP;
        return w;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a cycle / write.
    initial begin
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (bus.mem_we) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %h data %h with nothing expected", bus.mem_waddr, bus.mem_wdata);
                end else begin
                    w = wr_q.pop_front();
                    chk("mem_waddr", 32'(bus.mem_waddr), 32'(w.addr));
                    chk("mem_wdata", bus.mem_wdata, w.data);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ld_ready",    32'(bus.ld_ready),  32'(e.ld_ready));
                chk("mem_we",      32'(bus.mem_we),    32'(e.mem_we));
                chk("cpu_en",      32'(bus.cpu_en),    32'(e.cpu_en));
                chk("pc_out",      32'(bus.pc_out),    32'(e.pc));
                chk("halted",      32'(bus.halted),    32'(e.halted));
                chk("load_err",    32'(bus.load_err),  32'(e.load_err));
                chk("fetch_err",   32'(bus.fetch_err), 32'(e.fetch_err));
                chk("ld_count",    32'(bus.ld_count),  32'(e.ld_count));
                chk("instr_count", bus.instr_count,    e.instr_count);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] prog [6];
        int unsigned frozen;
        int n;
        prog[0] = 32'h80280032; prog[1] = 32'h85700000; prog[2] = 32'h00280064;
        prog[3] = 32'hA9A80001; prog[4] = 32'h89B80001; prog[5] = 32'hD2000014;
        idle();
        rst = 1;
        @(posedge clk); #1;

        // Load and run: HALT word at 6 survives a reset, program at 0..5.
        step(); step();
        rst = 0;
        bus.ld_valid = 1; bus.ld_addr = 16'd6; bus.ld_data = 32'hFC000000; step();
        idle(); rst = 1; step(); rst = 0;
        for (int i = 0; i < 6; i++) begin
            bus.ld_valid = 1; bus.ld_addr = 16'(i); bus.ld_data = prog[i]; step();
        end
        idle(); bus.ld_done = 1; step(); idle();
        chk("plan_ld_count", 32'(bus.ld_count), 32'd6);
        for (int i = 0; i < 10; i++) step();
        chk("plan_pc_halt", 32'(bus.pc_out), 32'd6);
        chk("plan_halted", 32'(bus.halted), 32'd1);
        chk("plan_instr_count", bus.instr_count, 32'd6);

        // Fill all of memory with non-HALT words for the redirect tests.
        rst = 1; step(); rst = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.ld_valid = 1; bus.ld_addr = 16'(i); bus.ld_data = rand_word(0); step();
        end
        idle(); bus.ld_done = 1; step(); idle();
        for (int i = 0; i < 10 && ref_pc != 5; i++) step();
        bus.redirect = 1; bus.redirect_pc = 16'd26; step();
        chk("redir_target", 32'(bus.pc_out), 32'd26);
        bus.redirect = 0; step();
        chk("redir_incr", 32'(bus.pc_out), 32'd27);
        bus.redirect = 1; bus.redirect_pc = 16'd3; step();
        frozen = ref_instr;
        bus.stall = 1; bus.redirect_pc = 16'd10;
        step(); step(); step();
        chk("stall_pc", 32'(bus.pc_out), 32'd3);
        chk("stall_instr", bus.instr_count, frozen);
        bus.stall = 0; step();
        chk("post_stall_redir", 32'(bus.pc_out), 32'd10);
        bus.redirect_pc = 16'd65; step();
        bus.redirect = 0; step();
        chk("incr_oob_pc", 32'(bus.pc_out), 32'd66);
        chk("incr_oob_err", 32'(bus.fetch_err), 32'd1);
        step(); step();

        // Reset mid-run, then redirect out of range.
        rst = 1; step(); rst = 0;
        bus.ld_done = 1; step(); idle();
        for (int i = 0; i < 4; i++) step();
        rst = 1; step(); rst = 0;
        chk("rst_pc", 32'(bus.pc_out), 32'd0);
        chk("rst_instr", bus.instr_count, 32'd0);
        chk("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
        bus.ld_done = 1; step(); idle(); step();
        bus.redirect = 1; bus.redirect_pc = 16'd66; step(); idle();
        chk("redir_oob_pc", 32'(bus.pc_out), 32'd66);
        chk("redir_oob_err", 32'(bus.fetch_err), 32'd1);
        step(); step();

        // Loader range error, ld_valid together with ld_done, loader ignored in RUN.
        rst = 1; step(); rst = 0;
        bus.ld_valid = 1; bus.ld_addr = 16'd70; bus.ld_data = 32'h12345678; step();
        chk("load_err_set", 32'(bus.load_err), 32'd1);
        chk("load_err_count", 32'(bus.ld_count), 32'd0);
        bus.ld_addr = 16'd2; bus.ld_data = 32'h0BADF00D; bus.ld_done = 1; step();
        bus.ld_done = 0;
        chk("done_write_count", 32'(bus.ld_count), 32'd1);
        bus.ld_addr = 16'd3;
        step(); step(); step();
        idle();

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            rst = 1; step(); rst = 0;
            n = $urandom_range(0, 20);
            for (int k = 0; k < n; k++) begin
                bus.ld_valid = ($urandom_range(0, 3) != 0);
                bus.ld_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(66, 200))
                                                           : 16'($urandom_range(0, 65));
                bus.ld_data  = rand_word(1);
                step();
            end
            bus.ld_valid = $urandom_range(0, 1);
            bus.ld_addr  = 16'($urandom_range(0, 65));
            bus.ld_data  = rand_word(1);
            bus.ld_done  = 1; step(); idle();
            for (int k = 0; k < 60; k++) begin
                bus.stall       = ($urandom_range(0, 3) == 0);
                bus.redirect    = ($urandom_range(0, 4) == 0);
                bus.redirect_pc = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(66, 70))
                                                               : 16'($urandom_range(0, 65));
                bus.ld_valid    = $urandom_range(0, 1);
                bus.ld_addr     = 16'($urandom_range(0, 65));
                bus.ld_data     = $urandom;
                step();
            end
            idle();
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("writes_drained", 32'(wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
